csr_access_ctrl_ysyx_23060136: RTL and testbench

Sequencer between the EXU/WBU and the single-read/single-write-port CSR register file. It serialises CSR instructions (CSRRW/CSRRS/CSRRC) and the multi-register trap sequences (ECALL, MRET) into one CSR-file access per cycle. It returns the old CSR value and any PC redirect via a valid/ready response channel.

---
 rtl/csr_access_ctrl_ysyx_23060136.sv | 215 +++++++++++++++++++++
 tb/tb_csr_access_ctrl_ysyx_23060136.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl_ysyx_23060136.sv
// CSR access sequencer: turns CSR instructions and ECALL/MRET trap sequences
// into single-port CSR-file accesses, one per cycle, with a registered response.
module csr_access_ctrl_ysyx_23060136 #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MCAUSE_ECALL = 32'd11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [2:0]      req_csr_idx,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [XLEN-1:0] req_pc,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_redirect,
    output logic [XLEN-1:0] resp_target,
    output logic            resp_illegal,
    output logic [2:0]      csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_wen,
    output logic [2:0]      csr_waddr,
    output logic [XLEN-1:0] csr_wdata
);

    localparam logic [2:0] OP_RW    = 3'd1;
    localparam logic [2:0] OP_RS    = 3'd2;
    localparam logic [2:0] OP_RC    = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    localparam logic [2:0] IDX_MSTATUS   = 3'd1;
    localparam logic [2:0] IDX_MTVEC     = 3'd2;
    localparam logic [2:0] IDX_MEPC      = 3'd3;
    localparam logic [2:0] IDX_MCAUSE    = 3'd4;
    localparam logic [2:0] IDX_MVENDORID = 3'd5;
    localparam logic [2:0] IDX_MARCHID   = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE, S_RW, S_EC_EPC, S_EC_CAUSE, S_EC_STAT, S_EC_VEC,
        S_MR_STAT, S_MR_EPC, S_ILL, S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [2:0]      idx_q, idx_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            redirect_q, redirect_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] new_val;

    // Read-only CSRs are legal only as pure reads (CSRRS/CSRRC with zero operand).
    function automatic state_e decode(input logic [2:0] op, input logic [2:0] idx,
                                      input logic wd_zero);
        state_e nxt;
        nxt = S_ILL;
        case (op)
            OP_RW, OP_RS, OP_RC: begin
                if (idx >= IDX_MSTATUS && idx <= IDX_MCAUSE)
                    nxt = S_RW;
                else if ((idx == IDX_MVENDORID || idx == IDX_MARCHID) && op != OP_RW && wd_zero)
                    nxt = S_RW;
            end
            OP_ECALL: nxt = S_EC_EPC;
            OP_MRET:  nxt = S_MR_STAT;
            default:  nxt = S_ILL;
        endcase
        return nxt;
    endfunction

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        rdata_d    = rdata_q;
        target_d   = target_q;
        redirect_d = redirect_q;
        illegal_d  = illegal_q;
        new_val    = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        csr_raddr  = '0;
        csr_wen    = 1'b0;
        csr_waddr  = '0;
        csr_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d    = req_op;
                    idx_d   = req_csr_idx;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    state_d = decode(req_op, req_csr_idx, req_wdata == '0);
                end
            end
            S_RW: begin
                csr_raddr = idx_q;
                rdata_d   = csr_rdata;
                case (op_q)
                    OP_RW:   new_val = wdata_q;
                    OP_RS:   new_val = csr_rdata | wdata_q;
                    default: new_val = csr_rdata & ~wdata_q;
                endcase
                // Set/clear with a zero operand is a pure read: no write side effects.
                csr_wen = (op_q == OP_RW) || (wdata_q != '0);
                if (csr_wen) begin
                    csr_waddr = idx_q;
                    csr_wdata = new_val;
                end
                state_d = S_RESP;
            end
            S_EC_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = IDX_MEPC;
                csr_wdata = pc_q;
                state_d   = S_EC_CAUSE;
            end
            S_EC_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = IDX_MCAUSE;
                csr_wdata = MCAUSE_ECALL;
                state_d   = S_EC_STAT;
            end
            S_EC_STAT: begin
                csr_raddr      = IDX_MSTATUS;
                new_val        = csr_rdata;
                new_val[7]     = csr_rdata[3];
                new_val[3]     = 1'b0;
                new_val[12:11] = 2'b11;
                csr_wen        = 1'b1;
                csr_waddr      = IDX_MSTATUS;
                csr_wdata      = new_val;
                state_d        = S_EC_VEC;
            end
            S_EC_VEC: begin
                csr_raddr  = IDX_MTVEC;
                target_d   = {csr_rdata[XLEN-1:2], 2'b00};
                redirect_d = 1'b1;
                state_d    = S_RESP;
            end
            S_MR_STAT: begin
                csr_raddr      = IDX_MSTATUS;
                new_val        = csr_rdata;
                new_val[3]     = csr_rdata[7];
                new_val[7]     = 1'b1;
                new_val[12:11] = 2'b00;
                csr_wen        = 1'b1;
                csr_waddr      = IDX_MSTATUS;
                csr_wdata      = new_val;
                state_d        = S_MR_EPC;
            end
            S_MR_EPC: begin
                csr_raddr  = IDX_MEPC;
                target_d   = csr_rdata;
                redirect_d = 1'b1;
                state_d    = S_RESP;
            end
            S_ILL: begin
                illegal_d = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                // Clear response fields on retire so an idle controller presents zeros.
                if (resp_ready) begin
                    rdata_d    = '0;
                    target_d   = '0;
                    redirect_d = 1'b0;
                    illegal_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            pc_q       <= '0;
            rdata_q    <= '0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            rdata_q    <= rdata_d;
            target_q   <= target_d;
            redirect_q <= redirect_d;
            illegal_q  <= illegal_d;
        end
    end

    assign resp_rdata    = rdata_q;
    assign resp_target   = target_q;
    assign resp_redirect = redirect_q;
    assign resp_illegal  = illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl_ysyx_23060136.sv
// Scoreboard bench for the CSR access sequencer: an architectural CSR model
// predicts each instruction's writes and response; a monitor checks them.
module tb_csr_access_ctrl_ysyx_23060136;

    localparam logic [31:0] MVENDOR = 32'h7973_7978;
    localparam logic [31:0] MARCH   = 32'h015f_df10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op, req_csr_idx;
    logic [31:0] req_wdata, req_pc;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata, resp_target;
    logic        resp_redirect, resp_illegal;
    logic [2:0]  csr_raddr, csr_waddr;
    logic [31:0] csr_rdata, csr_wdata;
    logic        csr_wen;

    csr_access_ctrl_ysyx_23060136 dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_idx(req_csr_idx), .req_wdata(req_wdata), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_redirect(resp_redirect), .resp_target(resp_target), .resp_illegal(resp_illegal),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_wen(csr_wen),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CSR file environment: plain RAM, read-only IDs come from constants.
    logic [31:0] mem [8];
    logic        env_ready = 1'b0;
    always @(posedge clk) begin
        if (!env_ready) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else if (csr_wen) begin
            mem[csr_waddr] <= csr_wdata;
        end
    end
    assign csr_rdata = (csr_raddr == 3'd5) ? MVENDOR :
                       (csr_raddr == 3'd6) ? MARCH   : mem[csr_raddr];

    typedef struct { logic [31:0] rdata; logic [31:0] target; logic redirect; logic illegal; int cyc; } exp_t;
    typedef struct { logic [2:0] addr; logic [31:0] data; int cyc; } wr_t;
    exp_t rq[$];
    wr_t  wq[$];
    logic [31:0] rcsr [8];

    int n_checks = 0, n_pass = 0;
    bit rand_rdy = 1'b0;
    int stall_until = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic pushw(input logic [2:0] a, input logic [31:0] d, input int c);
        wr_t w;
        w.addr = a; w.data = d; w.cyc = c;
        wq.push_back(w);
        rcsr[a] = d;
    endtask

    // Architectural model; c is the cycle count at the accepting negedge.
    task automatic model(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] wd,
                         input logic [31:0] pc, input bit abort, input int c);
        exp_t e;
        logic [31:0] old, nv;
        e.rdata = 0; e.target = 0; e.redirect = 0; e.illegal = 0; e.cyc = c + 2;
        case (op)
            3'd1, 3'd2, 3'd3: begin
                if ((idx >= 3'd1 && idx <= 3'd4) || ((idx == 3'd5 || idx == 3'd6) && op != 3'd1 && wd == 0)) begin
                    old = rcsr[idx];
                    e.rdata = old;
                    nv = (op == 3'd1) ? wd : (op == 3'd2) ? (old | wd) : (old & ~wd);
                    if (op == 3'd1 || wd != 0) pushw(idx, nv, c + 1);
                end else e.illegal = 1;
            end
            3'd4: begin
                pushw(3'd3, pc, c + 1);
                if (abort) return;
                pushw(3'd4, 32'd11, c + 2);
                old = rcsr[1];
                pushw(3'd1, (old & ~32'h1888) | 32'h1800 | (old[3] ? 32'h80 : 32'h0), c + 3);
                e.redirect = 1; e.target = rcsr[2] & ~32'h3; e.cyc = c + 5;
            end
            3'd5: begin
                old = rcsr[1];
                pushw(3'd1, (old & ~32'h1888) | 32'h80 | (old[7] ? 32'h8 : 32'h0), c + 1);
                e.redirect = 1; e.target = rcsr[3]; e.cyc = c + 3;
            end
            default: e.illegal = 1;
        endcase
        rq.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] wd,
                         input logic [31:0] pc, input bit abort = 0);
        int waitc = 0;
        @(negedge clk);
        while (!req_ready) begin
            if (waitc > 100) begin
                chk("req_ready_timeout", 32'(req_ready), 32'd1);
                return;
            end
            // Busy: present noise, which must be ignored.
            req_valid = 1'($urandom_range(0, 1));
            req_op = 3'($urandom); req_csr_idx = 3'($urandom);
            req_wdata = $urandom; req_pc = $urandom;
            waitc++;
            @(negedge clk);
        end
        req_valid = 1; req_op = op; req_csr_idx = idx; req_wdata = wd; req_pc = pc;
        model(op, idx, wd, pc, abort, cyc);
        @(negedge clk);
        req_valid = 0; req_op = 3'($urandom); req_wdata = $urandom;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_csr_wen"}, 32'(csr_wen), 32'd0);
        chk({tag, "_raddr"}, 32'(csr_raddr), 32'd0);
        chk({tag, "_waddr"}, 32'(csr_waddr), 32'd0);
        chk({tag, "_wdata"}, csr_wdata, 32'd0);
        chk({tag, "_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_target"}, resp_target, 32'd0);
        chk({tag, "_redirect"}, 32'(resp_redirect), 32'd0);
        chk({tag, "_illegal"}, 32'(resp_illegal), 32'd0);
    endtask

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cyc < stall_until) resp_ready = 1'b0;
            else if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
            else resp_ready = 1'b1;
        end
    end

    // Monitor: checks writes and responses against the scoreboard queues.
    initial begin
        bit pv;
        wr_t w;
        exp_t e;
        pv = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
                continue;
            end
            if (csr_wen) begin
                if (wq.size() == 0) chk("unexpected_write", {29'd0, csr_waddr}, 32'hffff_ffff);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(csr_waddr), 32'(w.addr));
                    chk("wr_data", csr_wdata, w.data);
                    chk("wr_cycle", 32'(cyc), 32'(w.cyc));
                end
            end
            if (resp_valid) begin
                chk("req_ready_while_resp", 32'(req_ready), 32'd0);
                if (rq.size() == 0) chk("unexpected_resp", resp_rdata, 32'hffff_ffff);
                else begin
                    e = rq[0];
                    if (!pv) chk("resp_latency", 32'(cyc), 32'(e.cyc));
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_target", resp_target, e.target);
                    chk("resp_redirect", 32'(resp_redirect), 32'(e.redirect));
                    chk("resp_illegal", 32'(resp_illegal), 32'(e.illegal));
                    if (resp_ready) void'(rq.pop_front());
                end
            end
            pv = resp_valid;
        end
    end

    initial begin
        int w;
        rst = 1; req_valid = 0; req_op = 0; req_csr_idx = 0; req_wdata = 0; req_pc = 0;
        for (int i = 0; i < 8; i++) rcsr[i] = 0;
        rcsr[5] = MVENDOR; rcsr[6] = MARCH;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        env_ready = 1;
        @(negedge clk);
        rst = 0;

        issue(3'd1, 3'd2, 32'h8000_0100, 0);          // CSRRW mtvec
        issue(3'd1, 3'd1, 32'h0000_1800, 0);          // mstatus = 0x1800
        issue(3'd2, 3'd1, 32'h0, 0);                  // pure read
        issue(3'd3, 3'd1, 32'h0000_0800, 0);          // clear MPP[0]
        issue(3'd1, 3'd2, 32'h8000_0103, 0);
        issue(3'd1, 3'd1, 32'h0000_0008, 0);
        issue(3'd4, 3'd0, 32'h0, 32'h8000_0040);      // ECALL
        issue(3'd1, 3'd3, 32'h8000_0044, 0);
        issue(3'd5, 3'd0, 32'h0, 0);                  // MRET
        issue(3'd1, 3'd6, 32'h1234, 0);               // illegal: write marchid
        issue(3'd2, 3'd5, 32'h1, 0);                  // illegal: set mvendorid
        issue(3'd1, 3'd0, 32'h5, 0);                  // illegal: unmapped
        issue(3'd7, 3'd1, 32'h5, 0);                  // illegal: bad op
        issue(3'd2, 3'd6, 32'h0, 0);                  // legal read of marchid
        issue(3'd0, 3'd1, 32'h0, 0);                  // NONE op
        issue(3'd2, 3'd1, 32'h0000_0002, 0);
        stall_until = cyc + 6;                        // hold resp_ready low
        issue(3'd3, 3'd4, 32'h0, 0);
        issue(3'd1, 3'd4, 32'h5, 0);                  // mcause = 5

        // Reset while the ECALL is writing mcause.
        issue(3'd4, 3'd0, 32'h0, 32'h8000_0200, 1);
        @(posedge clk);
        #2 rst = 1;
        #1 chk_idle("midop_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        issue(3'd2, 3'd4, 32'h0, 0);                  // mcause must still be 5
        issue(3'd2, 3'd3, 32'h0, 0);                  // mepc kept aborted ECALL pc

        rand_rdy = 1;
        for (int n = 0; n < 250; n++) begin
            logic [2:0]  op, idx;
            logic [31:0] wd;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op  = 3'($urandom_range(0, 7));
            idx = 3'($urandom_range(0, 7));
            wd  = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
            issue(op, idx, wd, $urandom & ~32'h3);
        end

        w = 0;
        while ((rq.size() != 0 || wq.size() != 0) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_resp_queue", 32'(rq.size()), 32'd0);
        chk("drain_write_queue", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
